// File: rtl/dma_copy_engine_pkg.sv
// Shared TileLink types and constants for the DMA copy engine.
// Also holds the engine's block-geometry constants and an address alignment helper.
package dma_copy_engine_pkg;

    localparam int DataWidth     = 128;
    localparam int AddrWidth     = 38;
    localparam int SourceWidth   = 3;
    localparam int SinkWidth     = 4;
    localparam int SizeWidth     = 4;
    localparam int MaskWidth     = DataWidth / 8;
    localparam int BeatsPerBlock = 4;

    localparam logic [2:0] TL_A_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    localparam logic [SizeWidth-1:0] BLOCK_SIZE_LG2 = 4'd6;
    localparam logic [AddrWidth-1:0] BLOCK_BYTES    = 38'd64;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             param;
        logic [SizeWidth-1:0]   size;
        logic [SourceWidth-1:0] source;
        logic [AddrWidth-1:0]   address;
        logic [MaskWidth-1:0]   mask;
        logic [DataWidth-1:0]   data;
        logic                   corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [1:0]             param;
        logic [SizeWidth-1:0]   size;
        logic [SourceWidth-1:0] source;
        logic [SinkWidth-1:0]   sink;
        logic                   denied;
        logic [DataWidth-1:0]   data;
        logic                   corrupt;
    } tl_d_t;

    // Forces an address onto a 64-byte block boundary.
    function automatic logic [AddrWidth-1:0] block_align(input logic [AddrWidth-1:0] addr);
        return {addr[AddrWidth-1:6], 6'b00_0000};
    endfunction

endpackage

// File: rtl/dma_copy_buf.sv
// Four-beat staging buffer holding one 64-byte block between the Get and the Put.
// Kept separate so it can be swapped for a BRAM or a deeper FIFO later.
module dma_copy_buf
    import dma_copy_engine_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           wr_idx,
    input  logic [DataWidth-1:0] wr_data,
    input  logic [1:0]           rd_idx,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem_r [BeatsPerBlock];

    // Beat storage, cleared on reset so stale data never leaves the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BeatsPerBlock; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/dma_copy_engine.sv
// TileLink host that copies memory block by block: Get 64 bytes, buffer the
// four response beats, PutFullData them to the destination, wait for the ack.
module dma_copy_engine
    import dma_copy_engine_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] src_i,
    input  logic [AddrWidth-1:0] dst_i,
    input  logic [15:0]          len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 dma_a_valid,
    input  logic                 dma_a_ready,
    output tl_a_t                dma_a,
    input  logic                 dma_b_valid,
    output logic                 dma_b_ready,
    output logic                 dma_c_valid,
    output logic                 dma_e_valid,
    input  logic                 dma_d_valid,
    output logic                 dma_d_ready,
    input  tl_d_t                dma_d
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_REQ,
        ST_GET_RESP,
        ST_PUT_REQ,
        ST_PUT_RESP,
        ST_FINISH
    } state_e;

    state_e               state_r, state_nxt_s;
    logic [1:0]           beat_r, beat_nxt_s;
    logic [AddrWidth-1:0] src_r, src_nxt_s;
    logic [AddrWidth-1:0] dst_r, dst_nxt_s;
    logic [15:0]          rem_r, rem_nxt_s;
    logic                 err_flag_r, err_flag_nxt_s;
    logic                 zero_pend_r, zero_pend_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 err_out_r, err_out_nxt_s;
    logic                 buf_we_s;
    logic                 beat_err_s;
    logic                 a_fire_s;
    logic                 d_fire_s;
    logic [DataWidth-1:0] buf_rd_s;
    logic                 unused_s;

    assign a_fire_s   = dma_a_valid && dma_a_ready;
    assign d_fire_s   = dma_d_valid && dma_d_ready;
    assign beat_err_s = dma_d.denied | dma_d.corrupt;

    dma_copy_buf u_buf (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (buf_we_s),
        .wr_idx  (beat_r),
        .wr_data (dma_d.data),
        .rd_idx  (beat_r),
        .rd_data (buf_rd_s)
    );

    // State and datapath registers; reset abandons any copy in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            beat_r      <= 2'd0;
            src_r       <= '0;
            dst_r       <= '0;
            rem_r       <= 16'd0;
            err_flag_r  <= 1'b0;
            zero_pend_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_out_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            beat_r      <= beat_nxt_s;
            src_r       <= src_nxt_s;
            dst_r       <= dst_nxt_s;
            rem_r       <= rem_nxt_s;
            err_flag_r  <= err_flag_nxt_s;
            zero_pend_r <= zero_pend_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            err_out_r   <= err_out_nxt_s;
        end
    end

    // Next-state and datapath update rules.
    always_comb begin
        state_nxt_s     = state_r;
        beat_nxt_s      = beat_r;
        src_nxt_s       = src_r;
        dst_nxt_s       = dst_r;
        rem_nxt_s       = rem_r;
        err_flag_nxt_s  = err_flag_r;
        zero_pend_nxt_s = zero_pend_r;
        buf_we_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    src_nxt_s      = block_align(src_i);
                    dst_nxt_s      = block_align(dst_i);
                    rem_nxt_s      = len_i;
                    err_flag_nxt_s = 1'b0;
                    beat_nxt_s     = 2'd0;
                    if (len_i == 16'd0) begin
                        // Zero-length copy spends one extra cycle so done lands at t+2.
                        state_nxt_s     = ST_FINISH;
                        zero_pend_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_GET_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GET_REQ: begin
                if (a_fire_s) begin
                    state_nxt_s = ST_GET_RESP;
                    beat_nxt_s  = 2'd0;
                end else begin
                    state_nxt_s = ST_GET_REQ;
                end
            end
            ST_GET_RESP: begin
                if (d_fire_s && (dma_d.opcode == TL_D_ACCESS_ACK_DATA)) begin
                    buf_we_s       = 1'b1;
                    beat_nxt_s     = beat_r + 2'd1;
                    err_flag_nxt_s = err_flag_r | beat_err_s;
                    if (beat_r == 2'd3) begin
                        // A faulty block is drained but never written back.
                        state_nxt_s = (err_flag_r | beat_err_s) ? ST_FINISH : ST_PUT_REQ;
                    end else begin
                        state_nxt_s = ST_GET_RESP;
                    end
                end else begin
                    state_nxt_s = ST_GET_RESP;
                end
            end
            ST_PUT_REQ: begin
                if (a_fire_s) begin
                    beat_nxt_s  = beat_r + 2'd1;
                    state_nxt_s = (beat_r == 2'd3) ? ST_PUT_RESP : ST_PUT_REQ;
                end else begin
                    state_nxt_s = ST_PUT_REQ;
                end
            end
            ST_PUT_RESP: begin
                if (d_fire_s && (dma_d.opcode == TL_D_ACCESS_ACK)) begin
                    err_flag_nxt_s = err_flag_r | dma_d.denied;
                    src_nxt_s      = src_r + BLOCK_BYTES;
                    dst_nxt_s      = dst_r + BLOCK_BYTES;
                    rem_nxt_s      = rem_r - 16'd1;
                    if ((rem_r == 16'd1) || err_flag_r || dma_d.denied) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_GET_REQ;
                    end
                end else begin
                    state_nxt_s = ST_PUT_RESP;
                end
            end
            ST_FINISH: begin
                if (zero_pend_r) begin
                    zero_pend_nxt_s = 1'b0;
                    state_nxt_s     = ST_FINISH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        done_nxt_s    = (state_nxt_s == ST_FINISH) && !zero_pend_nxt_s;
        busy_nxt_s    = (state_nxt_s != ST_IDLE) && !done_nxt_s;
        err_out_nxt_s = done_nxt_s && err_flag_nxt_s;
    end

    // A-channel request decode; payload derives only from registers so it holds while stalled.
    always_comb begin
        dma_a       = '0;
        dma_a_valid = 1'b0;
        case (state_r)
            ST_GET_REQ: begin
                dma_a_valid    = 1'b1;
                dma_a.opcode   = TL_A_GET;
                dma_a.size     = BLOCK_SIZE_LG2;
                dma_a.address  = src_r;
                dma_a.mask     = {MaskWidth{1'b1}};
            end
            ST_PUT_REQ: begin
                dma_a_valid    = 1'b1;
                dma_a.opcode   = TL_A_PUT_FULL_DATA;
                dma_a.size     = BLOCK_SIZE_LG2;
                dma_a.address  = dst_r;
                dma_a.mask     = {MaskWidth{1'b1}};
                dma_a.data     = buf_rd_s;
            end
            default: begin
                dma_a_valid = 1'b0;
            end
        endcase
    end

    assign dma_d_ready = rst_i || (state_r == ST_IDLE) || (state_r == ST_GET_RESP) ||
                         (state_r == ST_PUT_RESP);
    assign dma_b_ready = 1'b1;
    assign dma_c_valid = 1'b0;
    assign dma_e_valid = 1'b0;

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign err_o  = err_out_r;

    assign unused_s = ^{dma_b_valid, dma_d.param, dma_d.size, dma_d.source, dma_d.sink};

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: a memory/device model answers TileLink
// traffic while a transaction-level plan of expected A beats is checked every cycle.
module tb_dma_copy_engine;
    import dma_copy_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [37:0] src_i = 38'd0;
    logic [37:0] dst_i = 38'd0;
    logic [15:0] len_i = 16'd0;
    logic        busy_o, done_o, err_o;
    logic        a_valid;
    logic        a_ready = 1'b1;
    tl_a_t       a_pl;
    logic        b_ready, c_valid, e_valid;
    logic        d_valid = 1'b0;
    logic        d_ready;
    tl_d_t       d_pl = '0;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .dma_a_valid(a_valid), .dma_a_ready(a_ready), .dma_a(a_pl),
        .dma_b_valid(1'b0), .dma_b_ready(b_ready), .dma_c_valid(c_valid),
        .dma_e_valid(e_valid), .dma_d_valid(d_valid), .dma_d_ready(d_ready), .dma_d(d_pl)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct { logic [2:0] op; logic [37:0] addr; logic [127:0] data; } a_exp_t;

    a_exp_t      exp_a[$];
    tl_d_t       dq[$];
    logic [37:0] get_addrs[$];
    logic [127:0] mem [logic [37:0]];

    int cyc = 0;
    int start_cyc = 0;
    int get_cnt = 0, put_fires = 0, a_fires = 0, done_cnt = 0;
    int done_cyc = 0, first_a_cyc = -1, put_beat = 0;
    int deny_get = -1, deny_beat = 0;
    bit exp_err = 1'b0, stall_mode = 1'b0;
    bit hold_pend = 1'b0, d_consumed = 1'b0;
    tl_a_t hold_pl;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pattern(input logic [37:0] a);
        return {a, 26'h2AA_AAAA, ~a, 26'h155_5555};
    endfunction

    function automatic logic [127:0] mem_rd(input logic [37:0] a);
        if (mem.exists(a)) return mem[a];
        return pattern(a);
    endfunction

    // Expected A traffic for a copy, derived from the block-copy rules.
    task automatic plan(input logic [37:0] src, input logic [37:0] dst, input int len, input int err_blk);
        logic [37:0] s, d;
        s = {src[37:6], 6'd0};
        d = {dst[37:6], 6'd0};
        for (int i = 0; i < len; i++) begin
            exp_a.push_back('{3'd4, s, 128'd0});
            if (i == err_blk) break;
            for (int b = 0; b < 4; b++) exp_a.push_back('{3'd0, d, mem_rd(s + 38'(16 * b))});
            s = s + 38'd64;
            d = d + 38'd64;
        end
    endtask

    task automatic handle_a();
        a_exp_t e;
        tl_d_t  r;
        a_fires++;
        if (first_a_cyc < 0) first_a_cyc = cyc;
        if (exp_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected: got opcode %0d addr %0h, required no A beat", a_pl.opcode, a_pl.address);
        end else begin
            e = exp_a.pop_front();
            chk("a_opcode", a_pl.opcode, e.op);
            chk("a_address", a_pl.address, e.addr);
            chk("a_data", a_pl.data, e.data);
            chk("a_size", a_pl.size, 4'd6);
            chk("a_source", a_pl.source, 3'd0);
            chk("a_param", a_pl.param, 3'd0);
            chk("a_mask", a_pl.mask, 16'hFFFF);
            chk("a_corrupt", a_pl.corrupt, 1'b0);
        end
        if (a_pl.opcode == 3'd4) begin
            get_addrs.push_back(a_pl.address);
            for (int b = 0; b < 4; b++) begin
                r = '0;
                r.opcode = 3'd1;
                r.size   = 4'd6;
                r.denied = (get_cnt == deny_get) && (b == deny_beat);
                r.data   = mem_rd(a_pl.address + 38'(16 * b));
                dq.push_back(r);
            end
            get_cnt++;
        end else if (a_pl.opcode == 3'd0) begin
            mem[a_pl.address + 38'(16 * put_beat)] = a_pl.data;
            put_beat++;
            put_fires++;
            if (put_beat == 4) begin
                put_beat = 0;
                r = '0;
                r.opcode = 3'd0;
                r.size   = 4'd6;
                dq.push_back(r);
            end
        end
    endtask

    // Device model and per-cycle compare, running just after each falling edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_i) begin
            dq.delete();
            exp_a.delete();
            d_valid = 1'b0;
            d_consumed = 1'b0;
            a_ready = 1'b1;
            hold_pend = 1'b0;
            put_beat = 0;
        end else begin
            if (start_i && !busy_o && !done_o) begin
                done_cnt = 0; a_fires = 0; put_fires = 0; get_cnt = 0;
                first_a_cyc = -1; put_beat = 0;
                get_addrs.delete();
                mem.delete();
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy_low", busy_o, 1'b0);
                chk("done_err", err_o, exp_err);
            end
            if (hold_pend) begin
                chk("a_hold_valid", a_valid, 1'b1);
                chk("a_hold_payload", a_pl === hold_pl, 1'b1);
            end
            a_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (d_consumed) begin
                d_valid = 1'b0;
                d_consumed = 1'b0;
            end
            if (!d_valid && dq.size() > 0 && (!stall_mode || $urandom_range(0, 2) != 0)) begin
                d_valid = 1'b1;
                d_pl = dq[0];
            end
            hold_pend = a_valid && !a_ready;
            hold_pl = a_pl;
            if (d_valid && d_ready) begin
                void'(dq.pop_front());
                d_consumed = 1'b1;
            end
            if (a_valid && a_ready) handle_a();
        end
    end

    task automatic start_copy(input logic [37:0] s, input logic [37:0] d, input logic [15:0] l);
        @(negedge clk);
        start_i = 1'b1; src_i = s; dst_i = d; len_i = l;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_at_t1", busy_o, 1'b1);
        chk("a_valid_at_t1", a_valid, l != 16'd0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o within %0d cycles, required one", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_block(input string name, input logic [37:0] s, input logic [37:0] d);
        for (int b = 0; b < 4; b++) chk(name, mem_rd(d + 38'(16 * b)), pattern(s + 38'(16 * b)));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("d_ready_in_reset", d_ready, 1'b1);
        chk("b_ready_in_reset", b_ready, 1'b1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_err", err_o, 1'b0);
        chk("reset_a_valid", a_valid, 1'b0);
        chk("reset_d_ready", d_ready, 1'b1);
        chk("tie_b_ready", b_ready, 1'b1);
        chk("tie_c_valid", c_valid, 1'b0);
        chk("tie_e_valid", e_valid, 1'b0);

        // One block, zero-latency memory
        plan(38'h1000, 38'h2000, 1, -1);
        start_copy(38'h1000, 38'h2000, 16'd1);
        wait_done(200);
        chk("one_block_latency", done_cyc - first_a_cyc, 10);
        chk("one_block_get_addr", get_addrs[0], 38'h1000);
        chk_block("one_block_data", 38'h1000, 38'h2000);
        chk("one_block_pin_data", mem_rd(38'h2000),
            {38'h00_0000_1000, 26'h2AA_AAAA, 38'h3F_FFFF_EFFF, 26'h155_5555});
        chk("one_block_done_once", done_cnt, 1);
        chk("one_block_plan_drained", exp_a.size(), 0);

        // start_i while busy is ignored
        plan(38'h1000, 38'h2000, 1, -1);
        start_copy(38'h1000, 38'h2000, 16'd1);
        repeat (3) @(negedge clk);
        start_i = 1'b1; src_i = 38'h7000; dst_i = 38'h8000; len_i = 16'd5;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(200);
        repeat (20) @(negedge clk);
        chk("busy_start_a_beats", a_fires, 5);
        chk("busy_start_done_once", done_cnt, 1);
        chk("busy_start_idle", busy_o, 1'b0);

        // Back-pressure on A and D
        stall_mode = 1'b1;
        plan(38'h1000, 38'h2000, 3, -1);
        start_copy(38'h1000, 38'h2000, 16'd3);
        wait_done(3000);
        repeat (30) @(negedge clk);
        stall_mode = 1'b0;
        chk_block("bp_blk0", 38'h1000, 38'h2000);
        chk_block("bp_blk1", 38'h1040, 38'h2040);
        chk_block("bp_blk2", 38'h1080, 38'h2080);
        chk("bp_done_once", done_cnt, 1);
        chk("bp_plan_drained", exp_a.size(), 0);

        // Denied response beat aborts without writing
        deny_get = 0; deny_beat = 1; exp_err = 1'b1;
        plan(38'h4000, 38'h5000, 2, 0);
        start_copy(38'h4000, 38'h5000, 16'd2);
        wait_done(200);
        chk("err_no_puts", put_fires, 0);
        chk("err_beats_drained", dq.size(), 0);
        chk("err_single_get", get_addrs.size(), 1);
        chk("err_blk0_untouched", mem.exists(38'h5000), 0);
        chk("err_blk1_untouched", mem.exists(38'h5040), 0);
        chk("err_done_once", done_cnt, 1);
        deny_get = -1; exp_err = 1'b0;

        // Zero-length copy
        start_copy(38'h1000, 38'h2000, 16'd0);
        wait_done(20);
        chk("len0_done_at_t2", done_cyc - start_cyc, 2);
        chk("len0_no_a", a_fires, 0);

        // Unaligned source and destination
        plan(38'h1013, 38'h2027, 1, -1);
        start_copy(38'h1013, 38'h2027, 16'd1);
        wait_done(200);
        chk("unaligned_get_addr", get_addrs[0], 38'h1000);
        chk_block("unaligned_data", 38'h1000, 38'h2000);

        // Reset during the third Put beat
        begin
            int k = 0;
            plan(38'h1000, 38'h2000, 1, -1);
            start_copy(38'h1000, 38'h2000, 16'd1);
            while (put_fires < 2 && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("rst_at_put_beat2", a_valid && (a_pl.opcode == 3'd0), 1'b1);
            rst_i = 1'b1;
            @(negedge clk);
            chk("rst_a_valid_drop", a_valid, 1'b0);
            chk("rst_busy_drop", busy_o, 1'b0);
            chk("rst_no_done", done_o, 1'b0);
            rst_i = 1'b0;
            repeat (20) @(negedge clk);
            chk("rst_no_done_after", done_cnt, 0);
        end
        plan(38'h1000, 38'h2000, 1, -1);
        start_copy(38'h1000, 38'h2000, 16'd1);
        wait_done(200);
        chk_block("post_rst_data", 38'h1000, 38'h2000);
        chk("post_rst_done_once", done_cnt, 1);

        // Source address wrap
        plan(38'h3F_FFFF_FFC0, 38'h6000, 2, -1);
        start_copy(38'h3F_FFFF_FFC0, 38'h6000, 16'd2);
        wait_done(200);
        chk("wrap_get0", get_addrs[0], 38'h3F_FFFF_FFC0);
        chk("wrap_get1", get_addrs[1], 38'h0);
        chk_block("wrap_blk1", 38'h0, 38'h6040);
        chk("wrap_plan_drained", exp_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
